// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among
// NUM_REQ producers. A grant lasts up to MAX_BURST words, a full FIFO stalls
// the burst without dropping data, and full-stall cycles are counted.
//
// Ports:
//   clk_i         clock, all logic on posedge
//   rst_i         synchronous active-high reset
//   req_i         per-requester word valid (level, held until ack)
//   wdata_i       packed requester data, requester k at [k*WIDTH +: WIDTH]
//   fifo_full_i   FIFO full flag
//   gnt_o         one-hot grant, zero in IDLE
//   ack_o         one-hot, high when the owner's word is written
//   fifo_wr_en_o  FIFO write enable
//   fifo_wdata_o  FIFO write data (owner's slice in BURST, else 0)
//   busy_o        high while in BURST
//   owner_o       current or last owner index (registered)
//   stall_cnt_o   saturating count of full-stall cycles (registered)
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_WIDTH = 8,
    parameter int unsigned OWN_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*WIDTH-1:0] wdata_i,
    input  logic                     fifo_full_i,
    output logic [NUM_REQ-1:0]       gnt_o,
    output logic [NUM_REQ-1:0]       ack_o,
    output logic                     fifo_wr_en_o,
    output logic [WIDTH-1:0]         fifo_wdata_o,
    output logic                     busy_o,
    output logic [OWN_WIDTH-1:0]     owner_o,
    output logic [CNT_WIDTH-1:0]     stall_cnt_o
);

    localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [OWN_WIDTH-1:0] owner_q, owner_d;
    logic [OWN_WIDTH-1:0] rr_q, rr_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [CNT_WIDTH-1:0] stall_q, stall_d;

    logic [OWN_WIDTH-1:0] pick;
    logic                 pick_vld;
    logic                 own_req;
    logic                 wr;
    logic                 last_beat;
    logic [OWN_WIDTH-1:0] next_ptr;
    logic [NUM_REQ-1:0]   own_onehot;
    logic [WIDTH-1:0]     own_data;

    // First requester at or after rr_q, wrapping modulo NUM_REQ.
    always_comb begin
        int unsigned idx;
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(rr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!pick_vld && req_i[OWN_WIDTH'(idx)]) begin
                pick_vld = 1'b1;
                pick     = OWN_WIDTH'(idx);
            end
        end
    end

    // Owner-relative helpers.
    assign own_req    = req_i[owner_q];
    assign own_onehot = NUM_REQ'(1) << owner_q;
    assign own_data   = WIDTH'(wdata_i >> (32'(owner_q) * WIDTH));
    // Reset gates the write so the word presented in the reset cycle is kept.
    assign wr         = (state_q == BURST) && own_req && !fifo_full_i && !rst_i;
    assign last_beat  = (beat_q == BEAT_W'(MAX_BURST - 1));
    assign next_ptr   = (owner_q == OWN_WIDTH'(NUM_REQ - 1)) ? '0
                                                             : owner_q + OWN_WIDTH'(1);

    // Next-state and combinational outputs.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_d         = rr_q;
        beat_d       = beat_q;
        stall_d      = stall_q;
        gnt_o        = '0;
        ack_o        = '0;
        fifo_wr_en_o = 1'b0;
        fifo_wdata_o = '0;
        busy_o       = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = BURST;
                    owner_d = pick;
                    beat_d  = '0;
                end
            end
            BURST: begin
                gnt_o        = own_onehot;
                busy_o       = 1'b1;
                fifo_wdata_o = own_data;
                fifo_wr_en_o = wr;
                ack_o        = wr ? own_onehot : '0;
                if (wr) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (last_beat) begin
                        state_d = IDLE;
                        rr_d    = next_ptr;
                    end
                end else if (!own_req) begin
                    state_d = IDLE;
                    rr_d    = next_ptr;
                end else if (fifo_full_i) begin
                    // Full never ends a burst; only the debug counter moves.
                    if (stall_q != '1) begin
                        stall_d = stall_q + CNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            beat_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
            stall_q <= stall_d;
        end
    end

    assign owner_o     = owner_q;
    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: scenario tasks plus a randomized run, all
// checked cycle by cycle against a behavioural model of the arbitration rules.
// A second instance with a 3-bit stall counter shares the stimulus.
module tb_fifo_wr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned MB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic           full;

    logic [N-1:0] gnt, ack;
    logic         wr_en, busy;
    logic [W-1:0] wd;
    logic [1:0]   owner;
    logic [7:0]   stall;

    logic [N-1:0] gnt_s, ack_s;
    logic         wr_en_s, busy_s;
    logic [W-1:0] wd_s;
    logic [1:0]   owner_s;
    logic [2:0]   stall_s;

    fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB), .CNT_WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .wdata_i(wdata), .fifo_full_i(full),
        .gnt_o(gnt), .ack_o(ack), .fifo_wr_en_o(wr_en), .fifo_wdata_o(wd),
        .busy_o(busy), .owner_o(owner), .stall_cnt_o(stall)
    );

    fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB), .CNT_WIDTH(3)) dut_s (
        .clk_i(clk), .rst_i(rst), .req_i(req), .wdata_i(wdata), .fifo_full_i(full),
        .gnt_o(gnt_s), .ack_o(ack_s), .fifo_wr_en_o(wr_en_s), .fifo_wdata_o(wd_s),
        .busy_o(busy_s), .owner_o(owner_s), .stall_cnt_o(stall_s)
    );

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    // Behavioural model
    bit m_busy = 1'b0;
    int m_owner = 0, m_rr = 0, m_beats = 0, m_stall = 0, m_stall_s = 0;

    // Producers and logs
    int           rem [N];
    int           seq [N];
    logic [N-1:0] last_ack;
    int           wr_cyc[$];
    logic [W-1:0] wr_dat[$];
    logic [N-1:0] gnt_log[$];

    task automatic model_update();
        if (rst) begin
            m_busy = 1'b0; m_owner = 0; m_rr = 0; m_beats = 0; m_stall = 0; m_stall_s = 0;
        end else if (!m_busy) begin
            for (int i = 0; i < N; i++) begin
                if (req[(m_rr + i) % N]) begin
                    m_busy  = 1'b1;
                    m_owner = (m_rr + i) % N;
                    m_beats = 0;
                    break;
                end
            end
        end else if (req[m_owner] && full) begin
            if (m_stall < 255) m_stall++;
            if (m_stall_s < 7) m_stall_s++;
        end else if (req[m_owner]) begin
            m_beats++;
            if (m_beats == MB) begin
                m_busy = 1'b0;
                m_rr   = (m_owner + 1) % N;
            end
        end else begin
            m_busy = 1'b0;
            m_rr   = (m_owner + 1) % N;
        end
    endtask

    task automatic check();
        logic [N-1:0] e_gnt, e_ack;
        logic         e_wr;
        logic [W-1:0] e_wd;
        e_gnt = m_busy ? (N'(1) << m_owner) : '0;
        e_wr  = m_busy && req[m_owner] && !full && !rst;
        e_ack = e_wr ? e_gnt : '0;
        e_wd  = m_busy ? wdata[m_owner*W +: W] : '0;
        vectors++;
        if (gnt !== e_gnt) begin errors++; $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, gnt, e_gnt); end
        vectors++;
        if (ack !== e_ack) begin errors++; $display("FAIL ack cyc=%0d got=%b exp=%b", cyc, ack, e_ack); end
        vectors++;
        if (wr_en !== e_wr) begin errors++; $display("FAIL wr_en cyc=%0d got=%b exp=%b", cyc, wr_en, e_wr); end
        vectors++;
        if (wd !== e_wd) begin errors++; $display("FAIL wdata cyc=%0d got=%h exp=%h", cyc, wd, e_wd); end
        vectors++;
        if (busy !== m_busy) begin errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, m_busy); end
        vectors++;
        if (owner !== 2'(m_owner)) begin errors++; $display("FAIL owner cyc=%0d got=%0d exp=%0d", cyc, owner, m_owner); end
        vectors++;
        if (stall !== 8'(m_stall)) begin errors++; $display("FAIL stall cyc=%0d got=%0d exp=%0d", cyc, stall, m_stall); end
        vectors++;
        if (stall_s !== 3'(m_stall_s)) begin errors++; $display("FAIL stall_sat cyc=%0d got=%0d exp=%0d", cyc, stall_s, m_stall_s); end
        vectors++;
        if ({gnt_s, ack_s, wr_en_s, wd_s, busy_s, owner_s} !== {e_gnt, e_ack, e_wr, e_wd, m_busy, 2'(m_owner)}) begin
            errors++;
            $display("FAIL small_inst cyc=%0d got=%h exp=%h", cyc,
                     {gnt_s, ack_s, wr_en_s, wd_s, busy_s, owner_s}, {e_gnt, e_ack, e_wr, e_wd, m_busy, 2'(m_owner)});
        end
    endtask

    // Producers advance to the next word in the cycle after their ack.
    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (last_ack[k] === 1'b1) begin
                rem[k]--;
                seq[k]++;
            end
            req[k] = (rem[k] > 0);
            wdata[k*W +: W] = {4'(k), 4'(seq[k])};
        end
        last_ack = '0;
    endtask

    // One clock: sample mid-cycle, advance on posedge, re-drive after edge.
    task automatic step(input bit chk);
        #2;
        if (chk) check();
        last_ack = ack;
        if (wr_en === 1'b1) begin
            wr_cyc.push_back(cyc);
            wr_dat.push_back(wd);
        end
        gnt_log.push_back(gnt);
        @(posedge clk);
        model_update();
        cyc++;
        #1;
        drive();
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        full = 1'b0;
        for (int k = 0; k < N; k++) begin rem[k] = 0; seq[k] = 0; end
        last_ack = '0;
        drive();
        step(1'b0);
        rst = 1'b0;
        cyc = 0;
        wr_cyc.delete();
        wr_dat.delete();
        gnt_log.delete();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++;
        if ({gnt, ack, wr_en, wd, busy, owner, stall, stall_s} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", {gnt, ack, wr_en, wd, busy, owner, stall, stall_s});
        end
        #1;
        step(1'b1);
    endtask

    task automatic test_single_burst();
        int exp_c [6];
        exp_c = '{1, 2, 3, 4, 6, 7};
        do_reset();
        rem[0] = 6;
        drive();
        for (int c = 0; c < 10; c++) step(1'b1);
        vectors++;
        if (wr_cyc.size() != 6) begin
            errors++; $display("FAIL single_count got=%0d exp=6", wr_cyc.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                vectors++;
                if (wr_cyc[i] != exp_c[i] || wr_dat[i] !== 8'(i)) begin
                    errors++;
                    $display("FAIL single_word%0d got cyc=%0d data=%h exp cyc=%0d data=%h", i, wr_cyc[i], wr_dat[i], exp_c[i], 8'(i));
                end
            end
        end
        vectors++;
        if (gnt_log[5] !== 4'b0000 || gnt_log[6] !== 4'b0001 || gnt_log[9] !== 4'b0000) begin
            errors++;
            $display("FAIL single_bubble got=%b/%b/%b exp=0000/0001/0000", gnt_log[5], gnt_log[6], gnt_log[9]);
        end
    endtask

    task automatic test_round_robin();
        int cnt [N];
        int cnt1 [N];
        int exp_o [5];
        exp_o = '{0, 1, 2, 3, 0};
        do_reset();
        for (int k = 0; k < N; k++) begin rem[k] = 100; cnt[k] = 0; cnt1[k] = 0; end
        drive();
        for (int c = 0; c < 41; c++) step(1'b1);
        foreach (wr_dat[i]) begin
            cnt[32'(wr_dat[i][7:4])]++;
            if (wr_cyc[i] <= 20) cnt1[32'(wr_dat[i][7:4])]++;
        end
        for (int k = 0; k < N; k++) begin
            vectors++;
            if (cnt[k] != 8 || cnt1[k] != 4) begin
                errors++; $display("FAIL rr_acks req%0d got=%0d/%0d exp=8/4", k, cnt[k], cnt1[k]);
            end
        end
        vectors++;
        if (wr_dat.size() != 32) begin
            errors++; $display("FAIL rr_total got=%0d exp=32", wr_dat.size());
        end else begin
            for (int g = 0; g < 5; g++) begin
                vectors++;
                if (32'(wr_dat[g*4][7:4]) != exp_o[g]) begin
                    errors++; $display("FAIL rr_order grant%0d got=%0d exp=%0d", g, wr_dat[g*4][7:4], exp_o[g]);
                end
            end
        end
    endtask

    task automatic test_full_stall();
        int exp_c [4];
        exp_c = '{1, 2, 8, 9};
        do_reset();
        rem[2] = 4;
        drive();
        for (int c = 0; c < 12; c++) begin
            full = (c >= 3 && c <= 7);
            step(1'b1);
        end
        full = 1'b0;
        for (int c = 3; c <= 7; c++) begin
            vectors++;
            if (gnt_log[c] !== 4'b0100) begin
                errors++; $display("FAIL stall_gnt cyc=%0d got=%b exp=0100", c, gnt_log[c]);
            end
        end
        vectors++;
        if (wr_cyc.size() != 4) begin
            errors++; $display("FAIL stall_count got=%0d exp=4", wr_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (wr_cyc[i] != exp_c[i]) begin
                    errors++; $display("FAIL stall_wrcyc%0d got=%0d exp=%0d", i, wr_cyc[i], exp_c[i]);
                end
            end
        end
        vectors++;
        if (stall !== 8'd5 || stall_s !== 3'd5 || gnt_log[10] !== 4'b0000) begin
            errors++; $display("FAIL stall_cnt got=%0d/%0d gnt10=%b exp=5/5 gnt10=0000", stall, stall_s, gnt_log[10]);
        end
    endtask

    task automatic test_early_release();
        do_reset();
        rem[1] = 1;
        rem[3] = 2;
        drive();
        for (int c = 0; c < 8; c++) step(1'b1);
        vectors++;
        if (gnt_log[1] !== 4'b0010 || gnt_log[3] !== 4'b0000 || gnt_log[4] !== 4'b1000) begin
            errors++;
            $display("FAIL early_gnt got=%b/%b/%b exp=0010/0000/1000", gnt_log[1], gnt_log[3], gnt_log[4]);
        end
        vectors++;
        if (wr_cyc.size() != 3 || wr_cyc[0] != 1 || wr_cyc[1] != 4 || wr_cyc[2] != 5 || owner !== 2'd3) begin
            errors++; $display("FAIL early_writes got n=%0d owner=%0d exp n=3 cyc 1,4,5 owner=3", wr_cyc.size(), owner);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        rem[2] = 4;
        drive();
        step(1'b1);
        step(1'b1);
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        #2;
        vectors++;
        if ({gnt, ack, wr_en, wd, busy, owner, stall} !== '0) begin
            errors++; $display("FAIL rst_mid_outputs got=%h exp=0", {gnt, ack, wr_en, wd, busy, owner, stall});
        end
        rem[0] = 3; rem[1] = 3; rem[3] = 3;
        drive();
        for (int c = 3; c < 7; c++) step(1'b1);
        vectors++;
        if (wr_cyc.size() < 2 || wr_cyc[0] != 1 || wr_cyc[1] != 4 || wr_dat[1] !== 8'h00) begin
            errors++; $display("FAIL rst_mid_writes got n=%0d exp first writes at 1,4 from req0", wr_cyc.size());
        end
        vectors++;
        if (gnt_log[3] !== 4'b0000 || gnt_log[4] !== 4'b0001) begin
            errors++; $display("FAIL rst_mid_regrant got=%b/%b exp=0000/0001", gnt_log[3], gnt_log[4]);
        end
        #3;
    endtask

    task automatic test_stall_saturation();
        bit seen7;
        bit dropped;
        seen7   = 1'b0;
        dropped = 1'b0;
        do_reset();
        rem[1] = 30;
        drive();
        for (int c = 0; c < 16; c++) begin
            full = (c >= 2 && c < 12);
            step(1'b1);
            if (stall_s === 3'd7) seen7 = 1'b1;
            else if (seen7) dropped = 1'b1;
        end
        full = 1'b0;
        vectors++;
        if (stall_s !== 3'd7 || dropped || stall !== 8'd10) begin
            errors++; $display("FAIL stall_sat got=%0d dropped=%0d wide=%0d exp=7 0 10", stall_s, dropped, stall);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            full = ($urandom_range(0, 3) == 0);
            rst  = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < N; k++) begin
                if (rem[k] == 0 && $urandom_range(0, 2) == 0) rem[k] = $urandom_range(1, 6);
            end
            drive();
            step(1'b1);
        end
        rst  = 1'b0;
        full = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        req   = '0;
        wdata = '0;
        full  = 1'b0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_full_stall();
        test_early_release();
        test_reset_mid_burst();
        test_stall_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
